// File: rtl/alu_pkg.sv
// Shared definitions for the alu32 datapath and the two-client arbiter in front of it.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_W-1:0] ALU_MUL = 3'b011;
  localparam logic [OP_W-1:0] ALU_NOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_ILL = 3'b101;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  typedef struct packed {
    logic              err;
    logic              flagn;
    logic              flagz;
    logic [DATA_W-1:0] data;
  } alu_rsp_t;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; opcode 3'b101 is undefined and yields X.
module alu32
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              flagz,
  output logic              flagn
);

  logic [DATA_W-1:0] diff;

  assign diff = a - b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = diff;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_MUL: result = a * b;
      ALU_SLT: result = DATA_W'(diff[DATA_W-1]);
      default: result = 'x;
    endcase
  end

  assign flagz = (result == '0);
  assign flagn = result[DATA_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu32 between two valid/ready clients with a
// single tagged response channel; multiply holds operands for MUL_CYCLES.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flagz,
  output logic              rsp_flagn,
  output logic              rsp_err
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant;
  logic              take;
  logic [CNT_W-1:0]  cnt;
  alu_req_t          req_q;
  logic              id_q;
  alu_rsp_t          rsp_q;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;
  logic              alu_n;

  alu32 u_alu (
    .a      (req_q.a),
    .b      (req_q.b),
    .op     (req_q.op),
    .result (alu_out),
    .flagz  (alu_z),
    .flagn  (alu_n)
  );

  // Single requester wins outright; on contention the one not granted last wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        take       = req0_ready || req1_ready;
        if (take) state_nxt = EXEC;
      end
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, settle counter and response latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      req_q      <= '0;
      id_q       <= 1'b0;
      rsp_q      <= '0;
      rsp_id     <= 1'b0;
    end else if (take) begin
      req_q.a    <= grant ? req1_a : req0_a;
      req_q.b    <= grant ? req1_b : req0_b;
      req_q.op   <= grant ? req1_op : req0_op;
      id_q       <= grant;
      last_grant <= grant;
      cnt        <= ((grant ? req1_op : req0_op) == ALU_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
    end else if (state == EXEC) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        rsp_id <= id_q;
        // The ALU drives X for the illegal opcode, so it is never sampled then.
        if (req_q.op == ALU_ILL) begin
          rsp_q <= '{err: 1'b1, flagn: 1'b0, flagz: 1'b0, data: '0};
        end else begin
          rsp_q <= '{err: 1'b0, flagn: alu_n, flagz: alu_z, data: alu_out};
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_q.data;
  assign rsp_flagz = rsp_q.flagz;
  assign rsp_flagn = rsp_q.flagn;
  assign rsp_err   = rsp_q.err;

endmodule
